// File: rtl/acc_processor_param.sv
// Parametrised multi-cycle accumulator CPU: FETCH/EXEC per instruction, flags, conditional jumps,
// a valid/ready output port that stalls the core, and a HALT state left only through reset.
module acc_processor_param #(
  parameter int DATA_W  = 8,
  parameter int REG_NUM = 4,
  parameter int PC_W    = 5,
  parameter int INSTR_W = 4 + DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_ext,
  input  logic                       en,
  output logic [PC_W-1:0]            prog_addr,
  input  logic [INSTR_W-1:0]         prog_data,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       halted,
  output logic                       illegal,
  input  logic [$clog2(REG_NUM)-1:0] dbg_reg_sel,
  output logic [DATA_W-1:0]          reg_dbg,
  output logic [DATA_W-1:0]          acu_dbg,
  output logic [PC_W-1:0]            pc_dbg,
  output logic [1:0]                 flags_dbg,
  output logic [1:0]                 state_dbg
);

  localparam int RI_W = $clog2(REG_NUM);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    OUT_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [PC_W-1:0]     pc, pc_nxt;
  logic [DATA_W-1:0]   acu, acu_nxt;
  logic [INSTR_W-1:0]  ir, ir_nxt;
  logic [DATA_W-1:0]   regs [REG_NUM];
  logic                zero, zero_nxt, carry, carry_nxt;
  logic [DATA_W-1:0]   out_data_nxt;
  logic                out_valid_nxt, halted_nxt, illegal_nxt;
  logic                reg_we, set_zero;

  logic [3:0]          opcode;
  logic [DATA_W-1:0]   operand;
  logic [RI_W-1:0]     ridx;
  logic [DATA_W-1:0]   rval;
  logic [DATA_W:0]     sum, diff;

  assign opcode  = ir[INSTR_W-1 -: 4];
  assign operand = ir[DATA_W-1:0];
  assign ridx    = operand[RI_W-1:0];
  assign rval    = regs[ridx];
  // The extra top bit carries out of ADD and the borrow out of SUB.
  assign sum     = {1'b0, acu} + {1'b0, rval};
  assign diff    = {1'b0, acu} - {1'b0, rval};

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    acu_nxt       = acu;
    ir_nxt        = ir;
    zero_nxt      = zero;
    carry_nxt     = carry;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    halted_nxt    = halted;
    illegal_nxt   = illegal;
    reg_we        = 1'b0;
    set_zero      = 1'b0;
    case (state)
      FETCH: begin
        ir_nxt    = prog_data;
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        pc_nxt    = pc + 1'b1;
        case (opcode)
          4'h1: begin acu_nxt = operand;     set_zero = 1'b1; end
          4'h2: begin acu_nxt = rval;        set_zero = 1'b1; end
          4'h3: reg_we = 1'b1;
          4'h4: begin {carry_nxt, acu_nxt} = sum;  set_zero = 1'b1; end
          4'h5: begin {carry_nxt, acu_nxt} = diff; set_zero = 1'b1; end
          4'h6: begin acu_nxt = acu & rval;  set_zero = 1'b1; end
          4'h7: begin acu_nxt = acu | rval;  set_zero = 1'b1; end
          4'h8: begin acu_nxt = acu ^ rval;  set_zero = 1'b1; end
          4'h9: begin acu_nxt = ~acu;        set_zero = 1'b1; end
          4'hA: pc_nxt = operand[PC_W-1:0];
          4'hB: if (zero)  pc_nxt = operand[PC_W-1:0];
          4'hC: if (carry) pc_nxt = operand[PC_W-1:0];
          4'hD: begin
            out_data_nxt  = acu;
            out_valid_nxt = 1'b1;
            pc_nxt        = pc;
            state_nxt     = OUT_WAIT;
          end
          4'hE: begin
            halted_nxt = 1'b1;
            pc_nxt     = pc;
            state_nxt  = HALT;
          end
          4'hF: begin
            illegal_nxt = 1'b1;
            halted_nxt  = 1'b1;
            pc_nxt      = pc;
            state_nxt   = HALT;
          end
          default: ;
        endcase
        if (set_zero) zero_nxt = (acu_nxt == '0);
      end
      OUT_WAIT: begin
        // PC only advances once the consumer has taken the word.
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          pc_nxt        = pc + 1'b1;
          state_nxt     = FETCH;
        end
      end
      HALT: ;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext)  state <= FETCH;
    else if (en)  state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      pc        <= '0;
      acu       <= '0;
      ir        <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else if (en) begin
      pc        <= pc_nxt;
      acu       <= acu_nxt;
      ir        <= ir_nxt;
      zero      <= zero_nxt;
      carry     <= carry_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      halted    <= halted_nxt;
      illegal   <= illegal_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst_ext) begin
    if (rst_ext) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (en && reg_we) begin
      regs[ridx] <= acu;
    end
  end

  assign prog_addr = pc;
  assign reg_dbg   = regs[dbg_reg_sel];
  assign acu_dbg   = acu;
  assign pc_dbg    = pc;
  assign flags_dbg = {carry, zero};
  assign state_dbg = state;

endmodule

// File: tb/tb_acc_processor_param.sv
// Directed bench for acc_processor_param: table of single-ALU-op programs plus hand-written
// sequences for jumps, loops, output stalls, enable freeze, illegal opcode and async reset.
module tb_acc_processor_param;

  logic        clk = 1'b0;
  logic        rst_ext = 1'b0;
  logic        en = 1'b1;
  logic [4:0]  prog_addr;
  logic [11:0] prog_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        halted, illegal;
  logic [1:0]  dbg_reg_sel = 2'd0;
  logic [7:0]  reg_dbg, acu_dbg;
  logic [4:0]  pc_dbg;
  logic [1:0]  flags_dbg, state_dbg;

  logic [11:0] mem [32];
  int n_vec = 0;
  int n_bad = 0;

  assign prog_data = mem[prog_addr];

  acc_processor_param #(.DATA_W(8), .REG_NUM(4), .PC_W(5), .INSTR_W(12)) dut (
    .clk(clk), .rst_ext(rst_ext), .en(en),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .illegal(illegal),
    .dbg_reg_sel(dbg_reg_sel), .reg_dbg(reg_dbg), .acu_dbg(acu_dbg),
    .pc_dbg(pc_dbg), .flags_dbg(flags_dbg), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] opd);
    return {op, opd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 32; i++) mem[i] = ins(4'hE, 8'h00);
  endtask

  task automatic do_reset();
    rst_ext = 1'b1;
    @(posedge clk);
    #1;
    rst_ext = 1'b0;
  endtask

  // Runs until halted or budget exhausted; reports output-valid cycles and last output word.
  task automatic run_halt(input int maxc, output int nv, output logic [7:0] od);
    nv = 0;
    od = 8'h00;
    for (int c = 0; c < maxc && !halted; c++) begin
      tick();
      if (out_valid) begin
        nv++;
        od = out_data;
      end
    end
    chk("run_halted", {31'd0, halted}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] op;
    logic       pre;
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] exp_acu;
    logic       exp_z;
    logic       exp_c;
  } vec_t;

  vec_t vt [13];

  initial begin
    int nv;
    logic [7:0] od;
    logic [4:0] pc_s;
    logic [7:0] acu_s;
    logic [1:0] st_s;

    // op, carry preset, ACU, R1, expected ACU, zero, carry
    vt[0]  = '{4'h4, 1'b0, 8'h03, 8'h05, 8'h08, 1'b0, 1'b0};
    vt[1]  = '{4'h4, 1'b0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1};
    vt[2]  = '{4'h4, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vt[3]  = '{4'h5, 1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vt[4]  = '{4'h5, 1'b0, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
    vt[5]  = '{4'h5, 1'b1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0};
    vt[6]  = '{4'h6, 1'b1, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1};
    vt[7]  = '{4'h7, 1'b0, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
    vt[8]  = '{4'h8, 1'b1, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b1};
    vt[9]  = '{4'h9, 1'b0, 8'h0F, 8'h33, 8'hF0, 1'b0, 1'b0};
    vt[10] = '{4'h2, 1'b1, 8'h55, 8'h00, 8'h00, 1'b1, 1'b1};
    vt[11] = '{4'h0, 1'b0, 8'h42, 8'h00, 8'h42, 1'b0, 1'b0};
    vt[12] = '{4'h1, 1'b1, 8'h00, 8'h99, 8'h01, 1'b0, 1'b1};

    // Sequence A: basic program with output; also reset state.
    clr_mem();
    mem[0] = ins(4'h1, 8'd5); mem[1] = ins(4'h3, 8'd1); mem[2] = ins(4'h1, 8'd3);
    mem[3] = ins(4'h4, 8'd1); mem[4] = ins(4'hD, 8'd0); mem[5] = ins(4'hE, 8'd0);
    do_reset();
    chk("rst_pc", pc_dbg, 0);
    chk("rst_acu", acu_dbg, 0);
    chk("rst_flags", flags_dbg, 2'b01);
    chk("rst_state", state_dbg, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    run_halt(100, nv, od);
    dbg_reg_sel = 2'd1;
    #1;
    chk("a_pulses", nv, 1);
    chk("a_out", od, 8);
    chk("a_flags", flags_dbg, 2'b00);
    chk("a_pc", pc_dbg, 5);
    chk("a_r1", reg_dbg, 5);
    chk("a_state", state_dbg, 3);

    // Table: prefix sets carry, then one ALU op against R1.
    for (int i = 0; i < 13; i++) begin
      clr_mem();
      mem[0] = ins(4'h1, vt[i].pre ? 8'hFF : 8'h00);
      mem[1] = ins(4'h3, 8'd3);
      mem[2] = ins(4'h4, 8'd3);
      mem[3] = ins(4'h1, vt[i].r);
      mem[4] = ins(4'h3, 8'd1);
      mem[5] = ins(4'h1, vt[i].a);
      mem[6] = ins(vt[i].op, 8'd1);
      do_reset();
      run_halt(100, nv, od);
      chk($sformatf("v%0d_acu", i), acu_dbg, vt[i].exp_acu);
      chk($sformatf("v%0d_zero", i), flags_dbg[0], vt[i].exp_z);
      chk($sformatf("v%0d_carry", i), flags_dbg[1], vt[i].exp_c);
    end

    // Sequence B: JC taken / not taken.
    clr_mem();
    mem[0] = ins(4'h1, 8'hF0); mem[1] = ins(4'h3, 8'd0); mem[2] = ins(4'h1, 8'h20);
    mem[3] = ins(4'h4, 8'd0);  mem[4] = ins(4'hC, 8'd7);
    do_reset();
    run_halt(100, nv, od);
    chk("jc_pc", pc_dbg, 7);
    chk("jc_acu", acu_dbg, 8'h10);
    chk("jc_carry", flags_dbg[1], 1);
    mem[2] = ins(4'h1, 8'h01);
    do_reset();
    run_halt(100, nv, od);
    chk("jnc_pc", pc_dbg, 5);
    chk("jnc_acu", acu_dbg, 8'hF1);

    // Sequence C: SUB/JZ countdown loop.
    clr_mem();
    mem[0] = ins(4'h1, 8'd3); mem[1] = ins(4'h3, 8'd0); mem[2] = ins(4'h1, 8'd1);
    mem[3] = ins(4'h3, 8'd1); mem[4] = ins(4'h2, 8'd0); mem[5] = ins(4'h5, 8'd1);
    mem[6] = ins(4'h3, 8'd0); mem[7] = ins(4'hB, 8'd9); mem[8] = ins(4'hA, 8'd5);
    do_reset();
    run_halt(200, nv, od);
    dbg_reg_sel = 2'd0;
    #1;
    chk("loop_r0", reg_dbg, 0);
    chk("loop_pc", pc_dbg, 9);
    chk("loop_flags", flags_dbg, 2'b01);

    // Sequence D: output stall, then enable freeze while a handshake is offered.
    clr_mem();
    mem[0] = ins(4'h1, 8'h5A); mem[1] = ins(4'hD, 8'd0);
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    chk("stall_seen", out_valid, 1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h5A);
      chk("stall_pc", pc_dbg, 1);
      chk("stall_state", state_dbg, 2);
    end
    en = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("en0_valid", out_valid, 1);
    chk("en0_pc", pc_dbg, 1);
    en = 1'b1;
    tick();
    chk("hs_valid", out_valid, 0);
    chk("hs_pc", pc_dbg, 2);
    chk("hs_state", state_dbg, 0);

    // Sequence E: en=0 for 4 cycles mid-program (sequence A program).
    clr_mem();
    mem[0] = ins(4'h1, 8'd5); mem[1] = ins(4'h3, 8'd1); mem[2] = ins(4'h1, 8'd3);
    mem[3] = ins(4'h4, 8'd1); mem[4] = ins(4'hD, 8'd0);
    do_reset();
    for (int c = 0; c < 5; c++) tick();
    pc_s = pc_dbg; acu_s = acu_dbg; st_s = state_dbg;
    chk("pre_freeze_pc", pc_dbg, 2);
    en = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("frz_pc", pc_dbg, pc_s);
    chk("frz_acu", acu_dbg, acu_s);
    chk("frz_state", state_dbg, st_s);
    en = 1'b1;
    run_halt(100, nv, od);
    chk("frz_out", od, 8);
    chk("frz_end_pc", pc_dbg, 5);

    // Sequence F: illegal opcode at address 2, HALT is sticky.
    clr_mem();
    mem[0] = ins(4'h1, 8'd1); mem[1] = ins(4'h0, 8'd0); mem[2] = ins(4'hF, 8'd0);
    do_reset();
    run_halt(100, nv, od);
    for (int c = 0; c < 3; c++) tick();
    chk("ill_flag", illegal, 1);
    chk("ill_pc", pc_dbg, 2);
    chk("ill_state", state_dbg, 3);

    // Sequence G: PC wraps from 31 to 0.
    clr_mem();
    mem[0] = ins(4'hA, 8'd30); mem[30] = ins(4'h0, 8'd0); mem[31] = ins(4'h1, 8'd9);
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    chk("wrap_pc", pc_dbg, 0);
    chk("wrap_acu", acu_dbg, 9);

    // Sequence H: asynchronous reset in OUT_WAIT.
    clr_mem();
    mem[0] = ins(4'h1, 8'h5A); mem[1] = ins(4'hD, 8'd0);
    out_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 20 && !out_valid; c++) tick();
    chk("h_seen", out_valid, 1);
    #2;
    rst_ext = 1'b1;
    #1;
    chk("h_valid", out_valid, 0);
    chk("h_data", out_data, 0);
    chk("h_pc", pc_dbg, 0);
    chk("h_acu", acu_dbg, 0);
    chk("h_state", state_dbg, 0);
    chk("h_flags", flags_dbg, 2'b01);
    tick();
    rst_ext = 1'b0;
    out_ready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_processor_param.md
Name: acc_processor_param

Overview:
- Parametrised successor of the 8-bit two-register accumulator processor.
- Multi-cycle accumulator CPU with configurable data width, register-file depth and program-counter width.
- Adds status flags, conditional jumps, a halt state and a valid/ready output port.
- Fetches from an external combinational program memory and exposes debug state for the testbench.

Parameters:
DATA_W, 8, datapath, accumulator and register width; must be >= PC_W and >= clog2(REG_NUM)
REG_NUM, 4, number of general registers R0..R(REG_NUM-1); power of two, >= 2
PC_W, 5, program-counter width; program space is 2^PC_W words
INSTR_W, 4+DATA_W, instruction word: opcode [INSTR_W-1 -: 4], operand [DATA_W-1:0]

Ports:
clk  in  1  system clock, rising edge
rst_ext  in  1  asynchronous, active-high reset
en  in  1  run enable; low freezes all state
prog_addr  out  PC_W  program memory address (equals PC)
prog_data  in  INSTR_W  instruction word, combinational read of prog_addr
out_data  out  DATA_W  output port data
out_valid  out  1  output port valid
out_ready  in  1  output port ready
halted  out  1  core stopped (HLT or illegal opcode)
illegal  out  1  sticky, set on opcode 4'hF
dbg_reg_sel  in  clog2(REG_NUM)  register selected for readback
reg_dbg  out  DATA_W  R[dbg_reg_sel], combinational
acu_dbg  out  DATA_W  accumulator
pc_dbg  out  PC_W  program counter
flags_dbg  out  2  {carry, zero}
state_dbg  out  2  FSM state encoding

Behaviour:
- Reset (asynchronous, any state): PC=0, ACU=0, all R=0, IR=0, zero=1, carry=0, out_data=0, out_valid=0, halted=0, illegal=0, state=FETCH.
- FSM states, state_dbg encoding: FETCH=0, EXEC=1, OUT_WAIT=2, HALT=3.
- en=0: no register or state changes, including mid-OUT_WAIT; out_valid holds its value.
- FETCH: IR <= prog_data; go to EXEC. Every instruction costs 2 cycles, plus OUT stall cycles.
- EXEC performs the opcode, then sets PC <= PC+1 (mod 2^PC_W; wraps 2^PC_W-1 -> 0) unless the opcode is a taken jump. Default next state is FETCH.
- Register index is operand[clog2(REG_NUM)-1:0]; upper operand bits are ignored.
- Opcodes:
  - 0 NOP
  - 1 LDI: ACU=imm
  - 2 LD: ACU=R[i]
  - 3 ST: R[i]=ACU
  - 4 ADD: {carry,ACU}=ACU+R[i]
  - 5 SUB: ACU=ACU-R[i], carry=1 on borrow (ACU<R[i] unsigned)
  - 6 AND, 7 OR, 8 XOR: ACU op R[i]
  - 9 NOT: ACU=~ACU
  - A JMP: PC=operand[PC_W-1:0]
  - B JZ: jump if zero=1
  - C JC: jump if carry=1
  - D OUT
  - E HLT
  - F illegal
- Flags:
  - zero = (new ACU==0), updated by opcodes 1,2,4-9 only.
  - carry is updated by ADD/SUB only; every other opcode leaves it unchanged.
  - Flags used by JZ/JC are the values before the jump executes.
- OUT: in EXEC, out_data <= ACU and out_valid <= 1; go to OUT_WAIT.
  - OUT_WAIT holds out_valid=1 and stable out_data until a cycle with out_ready=1.
  - On that handshake edge: out_valid <= 0, PC advances, state=FETCH.
  - out_ready asserted early has no effect; the handshake only completes in OUT_WAIT.
- HLT: halted <= 1, state=HALT. PC does not advance (pc_dbg shows the HLT address).
- Opcode F: illegal <= 1, halted <= 1, state=HALT.
- HALT is left only via rst_ext.
- Reset asserted mid-OUT_WAIT drops out_valid immediately, asynchronously.

Test Plan:
- Reset, then program LDI 5; ST R1; LDI 3; ADD R1; OUT; HLT with out_ready=1 -> out_data=8 with one valid pulse, zero=0, carry=0, halted=1, pc_dbg=5, R1=5.
- DATA_W=8: LDI 8'hF0; ST R0; LDI 8'h20; ADD R0; JC 7 -> ACU=8'h10, carry=1, PC=7 after the jump; with no carry (LDI 8'h01) PC instead falls through to 5.
- SUB/JZ loop: LDI 3; ST R0; LDI 1; ST R1; LD R0; SUB R1; ST R0; JZ 9; JMP 5; HLT -> R0 reaches 0 after 3 iterations, halted with pc_dbg=9.
- OUT stall: OUT with out_ready=0 for 6 cycles -> out_valid stays 1, out_data stable, PC frozen; out_ready=1 completes in 1 cycle and PC increments.
- en=0 held 4 cycles mid-program -> pc_dbg, acu_dbg and state_dbg unchanged; execution resumes identically.
- Opcode 4'hF at address 2 -> illegal=1, halted=1, pc_dbg=2. rst_ext pulse mid-OUT_WAIT -> all outputs return to reset values asynchronously.
